// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: shared state and PC-select encodings for the 18-bit core sequencer.
//   Contents: seq_state_t, SEQ_IDLE..SEQ_FAULT state codes, and PCSEL_INC/BRANCH/JUMP select codes.
package cpu_sequencer_pkg;
   typedef logic [2:0] seq_state_t;
   localparam logic [2:0] SEQ_IDLE   = 3'd0;
   localparam logic [2:0] SEQ_FETCH  = 3'd1;
   localparam logic [2:0] SEQ_DECODE = 3'd2;
   localparam logic [2:0] SEQ_EXEC   = 3'd3;
   localparam logic [2:0] SEQ_MEM    = 3'd4;
   localparam logic [2:0] SEQ_WB     = 3'd5;
   localparam logic [2:0] SEQ_FAULT  = 3'd6;
   localparam logic [1:0] PCSEL_INC    = 2'b00;
   localparam logic [1:0] PCSEL_BRANCH = 2'b01;
   localparam logic [1:0] PCSEL_JUMP   = 2'b10;
endpackage

// File: rtl/seq_timeout.sv
// seq_timeout: memory-handshake wait counter for the sequencer watchdog.
//   Ports: i_clk, i_rst_n (async, active-low), i_en (count one waiting cycle),
//          i_clr (return to 0), o_expired (count has reached TIMEOUT_CYCLES).
//   The counter never runs past TIMEOUT_CYCLES+1, because the sequencer leaves
//   the waiting state as soon as o_expired is seen with no ack.
module seq_timeout #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_expired
);
   logic [7:0] cnt;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) cnt <= '0;
      else cnt <= i_clr ? 8'd0 : i_en ? cnt + 8'd1 : cnt;
   assign o_expired = cnt == 8'(TIMEOUT_CYCLES);
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 18-bit core.
//   Inputs : i_clk, i_rst_n (async, active-low), i_run, i_clear_fault, decoder flags
//            (i_pc_src, i_branch, i_memRead, i_memWrite, i_regWrite), i_alu_zero,
//            i_imem_ack, i_dmem_ack.
//   Outputs: o_imem_req, o_dmem_req, o_dmem_we, o_ir_load, o_pc_en, o_pc_sel,
//            o_reg_we, o_busy, o_fault, o_state, o_retired_cnt.
//   Optional: define PERF_COUNTER_EN to build the retired-instruction counter;
//            otherwise o_retired_cnt is tied to 0.
//   All outputs are decoded from the state register and the ack inputs, so an
//   asynchronous reset forces every output to 0 without waiting for a clock.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_run,
   input  logic                 i_clear_fault,
   input  logic                 i_pc_src,
   input  logic                 i_branch,
   input  logic                 i_alu_zero,
   input  logic                 i_memRead,
   input  logic                 i_memWrite,
   input  logic                 i_regWrite,
   input  logic                 i_imem_ack,
   input  logic                 i_dmem_ack,
   output logic                 o_imem_req,
   output logic                 o_dmem_req,
   output logic                 o_dmem_we,
   output logic                 o_ir_load,
   output logic                 o_pc_en,
   output logic [1:0]           o_pc_sel,
   output logic                 o_reg_we,
   output logic                 o_busy,
   output logic                 o_fault,
   output logic [2:0]           o_state,
   output logic [CNT_WIDTH-1:0] o_retired_cnt
);
   seq_state_t state, state_nxt, ret_state;
   logic fetch, exec, mem, wb, fault, taken, mem_op, retire, wait_cyc, expired;
   assign fetch  = state == SEQ_FETCH;
   assign exec   = state == SEQ_EXEC;
   assign mem    = state == SEQ_MEM;
   assign wb     = state == SEQ_WB;
   assign fault  = state == SEQ_FAULT;
   assign taken  = i_branch & ~i_alu_zero;
   assign mem_op = i_memRead | i_memWrite;
   // Control-flow and NOP instructions finish in EXEC; stores finish on the
   // data ack; loads and ALU writes finish in WB.
   assign retire = (exec & (i_pc_src | i_branch | ~(mem_op | i_regWrite)))
                 | (mem & i_dmem_ack & ~i_memRead) | wb;
   // Only an outstanding request is timed; a stray ack elsewhere does nothing.
   assign wait_cyc  = (fetch & ~i_imem_ack) | (mem & ~i_dmem_ack);
   assign ret_state = i_run ? SEQ_FETCH : SEQ_IDLE;
   always_comb
      state_nxt = retire                  ? ret_state
                : state == SEQ_IDLE       ? (i_run ? SEQ_FETCH : SEQ_IDLE)
                : fetch                   ? (i_imem_ack ? SEQ_DECODE : expired ? SEQ_FAULT : SEQ_FETCH)
                : state == SEQ_DECODE     ? SEQ_EXEC
                : exec                    ? (mem_op ? SEQ_MEM : SEQ_WB)
                : mem                     ? (i_dmem_ack ? SEQ_WB : expired ? SEQ_FAULT : SEQ_MEM)
                : fault                   ? (i_clear_fault ? SEQ_IDLE : SEQ_FAULT)
                :                           SEQ_IDLE;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state <= SEQ_IDLE;
      else state <= state_nxt;
   seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (wait_cyc),
      .i_clr     (~wait_cyc),
      .o_expired (expired)
   );
   assign o_imem_req = fetch;
   assign o_ir_load  = fetch & i_imem_ack;
   assign o_dmem_req = mem;
   assign o_dmem_we  = mem & i_memWrite;
   assign o_pc_en    = (fetch & i_imem_ack) | (exec & (i_pc_src | taken));
   assign o_pc_sel   = (exec & i_pc_src) ? PCSEL_JUMP : (exec & taken) ? PCSEL_BRANCH : PCSEL_INC;
   assign o_reg_we   = wb;
   assign o_busy     = state != SEQ_IDLE && state <= SEQ_WB;
   assign o_fault    = fault;
   assign o_state    = state;
`ifdef PERF_COUNTER_EN
   logic [CNT_WIDTH-1:0] retired_cnt;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) retired_cnt <= '0;
      else if (retire) retired_cnt <= retired_cnt + 1'b1;
   assign o_retired_cnt = retired_cnt;
`else
   assign o_retired_cnt = '0;
`endif
endmodule
